// File: rtl/imem_loader_if.sv
// Word stream in, byte writes out: the loader is master, the source/memory side is slave.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads 32-bit words big-endian into byte memory and holds the CPU; IMEM_LOADER_CHECKSUM_EN adds a word-sum port.
// Latency: 1 accept + 4 write cycles per word. Backpressure: in_ready only in ACCEPT; the source holds its word otherwise.
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  imem_loader_if.master     bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              wrap_err
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       word;
  logic [1:0]        k;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[8*(3-idx) +: 8];
  endfunction

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      word        <= '0;
      k           <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap_err    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ptr      <= base_addr;
            cnt      <= word_count;
            wrap_err <= 1'b0;
            busy     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end

        // The first byte goes out on the handshake edge itself.
        ACCEPT: begin
          if (bus.in_valid) begin
            word        <= bus.in_data;
            k           <= 2'd0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ptr;
            mem_wdata_q <= bus.in_data[31:24];
            ptr         <= ptr + 1'b1;
            if (ptr == ADDR_TOP) wrap_err <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum    <= checksum + bus.in_data;
`endif
            state       <= WRITE;
          end
        end

        WRITE: begin
          if (k != 2'd3) begin
            k           <= k + 2'd1;
            mem_addr_q  <= ptr;
            mem_wdata_q <= byte_of(word, k + 2'd1);
            ptr         <= ptr + 1'b1;
            // Wrapping after the very last byte of the load is not an error.
            if (ptr == ADDR_TOP && !(k == 2'd2 && cnt == CNT_ONE)) wrap_err <= 1'b1;
          end else begin
            mem_we_q <= 1'b0;
            cnt      <= cnt - 1'b1;
            if (cnt == CNT_ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected byte writes and done events; a negedge monitor pops and compares.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  base_addr;
  logic [3:0]  word_count;
  logic        busy, cpu_hold, done, wrap_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(5)) bus ();

  imem_loader #(.ADDR_W(5), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .wrap_err   (wrap_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic [12:0] exp_wr[$];
  logic        exp_done[$];
  logic [12:0] got_wr;
  logic        exp_wrap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        checks++;
        got_wr = {bus.mem_addr, bus.mem_wdata};
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", bus.mem_addr, bus.mem_wdata);
        end else if (got_wr !== exp_wr[0]) begin
          errors++;
          $display("FAIL wr: got addr %0h data %0h expected addr %0h data %0h",
                   bus.mem_addr, bus.mem_wdata, exp_wr[0][12:8], exp_wr[0][7:0]);
          void'(exp_wr.pop_front());
        end else begin
          void'(exp_wr.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          exp_wrap = exp_done.pop_front();
          if (wrap_err !== exp_wrap) begin
            errors++;
            $display("FAIL done_wrap_err: got %0b expected %0b", wrap_err, exp_wrap);
          end
        end
      end
    end
  end

  task automatic do_start(input logic [4:0] b, input logic [3:0] n);
    @(negedge clk);
    start = 1'b1; base_addr = b; word_count = n;
    @(negedge clk);
    start = 1'b0; base_addr = 5'h0; word_count = 4'h0;
  endtask

  // Called at a negedge; waits `gap` idle cycles in ACCEPT, then hands over one word.
  task automatic send_word(input logic [31:0] w, input int gap, input logic [4:0] addr);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'h1);
      return;
    end
    for (int g = 0; g < gap; g++) begin
      chk("in_ready_wait", 32'(bus.in_ready), 32'h1);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 4; i++) exp_wr.push_back({5'(addr + 5'(i)), w[31-8*i -: 8]});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = w ^ 32'hDEADBEEF;
  endtask

  task automatic wait_done(input int prev);
    int t = 0;
    while (done_seen == prev && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (done_seen == prev) chk("done_timeout", 32'(done_seen), 32'(prev + 1));
  endtask

  initial begin
    int d;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wrap_err", 32'(wrap_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word at 4..7
    d = done_seen;
    exp_done.push_back(1'b0);
    do_start(5'h04, 4'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 1);
    send_word(32'h8C220000, 0, 5'h04);
    wait_done(d);
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_wrap_err", 32'(wrap_err), 0);
    chk("t1_drain", 32'(exp_wr.size()), 0);

    // Back-pressure, plus an ignored start mid-load
    d = done_seen;
    exp_done.push_back(1'b0);
    do_start(5'h00, 4'd3);
    send_word(32'h11111111, 3, 5'h00);
    do_start(5'h10, 4'd5);
    send_word(32'h22222222, 3, 5'h04);
    send_word(32'h33333333, 3, 5'h08);
    wait_done(d);
    chk("t2_cpu_hold_done", 32'(cpu_hold), 1);
    @(negedge clk);
    chk("t2_cpu_hold_after", 32'(cpu_hold), 0);
    chk("t2_drain", 32'(exp_wr.size()), 0);

    // Wrap past the top address
    d = done_seen;
    exp_done.push_back(1'b1);
    do_start(5'h1E, 4'd1);
    send_word(32'hAABBCCDD, 0, 5'h1E);
    wait_done(d);
    repeat (5) @(negedge clk);
    chk("t3_wrap_sticky", 32'(wrap_err), 1);

    // Zero count: done one cycle after start, clears wrap_err
    exp_done.push_back(1'b0);
    do_start(5'h00, 4'd0);
    chk("t4_done", 32'(done), 1);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_in_ready", 32'(bus.in_ready), 0);
    chk("t4_wrap_cleared", 32'(wrap_err), 0);
    @(negedge clk);
    chk("t4_done_after", 32'(done), 0);
    chk("t4_busy_after", 32'(busy), 0);

    // Reset during the second byte of the first word
    do_start(5'h00, 4'd2);
    send_word(32'h01020304, 0, 5'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t5_pre_addr", 32'(bus.mem_addr), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mem_we", 32'(bus.mem_we), 0);
    chk("t5_mem_addr", 32'(bus.mem_addr), 0);
    chk("t5_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_in_ready", 32'(bus.in_ready), 0);
    exp_wr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    d = done_seen;
    repeat (5) @(negedge clk);
    #1;
    chk("t5_no_done", 32'(done_seen), 32'(d));
    d = done_seen;
    exp_done.push_back(1'b0);
    do_start(5'h08, 4'd1);
    send_word(32'hCAFEF00D, 1, 5'h08);
    wait_done(d);
    chk("t5_drain", 32'(exp_wr.size()), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    d = done_seen;
    exp_done.push_back(1'b0);
    do_start(5'h10, 4'd2);
    send_word(32'hFFFFFFFF, 0, 5'h10);
    send_word(32'h00000002, 0, 5'h14);
    wait_done(d);
    chk("t6_checksum", checksum, 32'h00000001);
`endif

    repeat (3) @(negedge clk);
    chk("final_done_queue", 32'(exp_done.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
